ex: RTL and testbench

//  Execute stage of the 16-bit pipeline; sits between id_ex and ex_mem. Consumes the latched decode

---
 rtl/ex_pkg.sv | 53 +++++
 rtl/ex_muldiv_seq.sv | 142 ++++++++++++++
 rtl/ex.sv | 142 ++++++++++++++
 tb/tb_ex.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared codes for the execute stage.
//   ALUSEL_*  : operation class driven on ex_alusel
//   ALUOP_*   : operation within a class driven on ex_aluop
//   STALL_*, WRITE_*, RST_ENABLE : control levels used by the pipeline
//   md_state_t: states of the iterative multiply/divide unit
package ex_pkg;

    localparam logic [2:0] ALUSEL_NOP    = 3'd0;
    localparam logic [2:0] ALUSEL_LOGIC  = 3'd1;
    localparam logic [2:0] ALUSEL_SHIFT  = 3'd2;
    localparam logic [2:0] ALUSEL_ARITH  = 3'd3;
    localparam logic [2:0] ALUSEL_MOVE   = 3'd4;
    localparam logic [2:0] ALUSEL_MULDIV = 3'd5;

    localparam logic [2:0] ALUOP_AND  = 3'd0;
    localparam logic [2:0] ALUOP_OR   = 3'd1;
    localparam logic [2:0] ALUOP_XOR  = 3'd2;
    localparam logic [2:0] ALUOP_NOT  = 3'd3;

    localparam logic [2:0] ALUOP_SLL  = 3'd0;
    localparam logic [2:0] ALUOP_SRL  = 3'd1;
    localparam logic [2:0] ALUOP_SRA  = 3'd2;

    localparam logic [2:0] ALUOP_ADD  = 3'd0;
    localparam logic [2:0] ALUOP_SUB  = 3'd1;
    localparam logic [2:0] ALUOP_SLT  = 3'd2;
    localparam logic [2:0] ALUOP_SLTU = 3'd3;
    localparam logic [2:0] ALUOP_NEQ  = 3'd4;

    localparam logic [2:0] ALUOP_MOV  = 3'd0;

    localparam logic [2:0] ALUOP_MUL  = 3'd0;
    localparam logic [2:0] ALUOP_DIVU = 3'd1;
    localparam logic [2:0] ALUOP_REMU = 3'd2;

    localparam logic STALL_YES     = 1'b1;
    localparam logic STALL_NO      = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // True for the op codes the multiply/divide unit actually implements.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == ALUOP_MUL) || (op == ALUOP_DIVU) || (op == ALUOP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative unsigned multiply / divide unit, one bit per cycle.
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : request a new operation (honoured only in IDLE)
//   i_hold          : downstream freeze; keeps the unit in DONE with a stable result
//   i_op            : ALUOP_MUL / ALUOP_DIVU / ALUOP_REMU
//   i_a, i_b        : operands, captured at start
//   o_busy, o_done  : FSM in BUSY / DONE
//   o_result        : product low half, quotient or remainder (valid in DONE)
module ex_muldiv_seq
    import ex_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MD_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_hold,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);

    localparam int CNT_W = $clog2(MD_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_STEPS - 1);

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    // r_acc: product accumulator (MUL) or partial remainder (DIV/REM)
    // r_q  : multiplier shifted right (MUL) or dividend/quotient shifted left (DIV/REM)
    // r_b  : multiplicand shifted left (MUL) or divisor (DIV/REM)
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_b;

    logic [DATA_W:0]   w_rem_sh;
    logic              w_ge;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_sum;

    // Restoring-division step: bring down the next dividend bit and trial-subtract.
    // When the trial succeeds the true difference is below the divisor, so the
    // truncated subtraction is exact.
    assign w_rem_sh = {r_acc, r_q[DATA_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[DATA_W-1:0] - r_b;
    assign w_sum    = r_acc + r_b;

    // Control FSM plus the datapath registers it steers.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_cnt <= '0;
                        if ((i_op != ALUOP_MUL) && (i_b == '0)) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            r_q     <= '1;
                            r_acc   <= i_a;
                            r_b     <= i_b;
                            r_state <= MD_DONE;
                        end else if (i_op == ALUOP_MUL) begin
                            r_q     <= i_b;
                            r_b     <= i_a;
                            r_acc   <= '0;
                            r_state <= MD_BUSY;
                        end else begin
                            r_q     <= i_a;
                            r_b     <= i_b;
                            r_acc   <= '0;
                            r_state <= MD_BUSY;
                        end
                    end else begin
                        r_state <= MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (r_op == ALUOP_MUL) begin
                        if (r_q[0]) begin
                            r_acc <= w_sum;
                        end else begin
                            r_acc <= r_acc;
                        end
                        r_b <= r_b << 1;
                        r_q <= r_q >> 1;
                    end else begin
                        if (w_ge) begin
                            r_acc <= w_diff;
                            r_q   <= {r_q[DATA_W-2:0], 1'b1};
                        end else begin
                            r_acc <= w_rem_sh[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= MD_DONE;
                    end else begin
                        r_state <= MD_BUSY;
                    end
                end
                MD_DONE: begin
                    if (i_hold == STALL_YES) begin
                        r_state <= MD_DONE;
                    end else begin
                        r_state <= MD_IDLE;
                    end
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_done = (r_state == MD_DONE);

    // Result select by the latched op; decoded from registers only.
    always_comb begin
        o_result = '0;
        case (r_op)
            ALUOP_MUL:  o_result = r_acc;
            ALUOP_DIVU: o_result = r_q;
            ALUOP_REMU: o_result = r_acc;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex.sv
// ex: execute stage between id_ex and ex_mem.
//   clk, rst                     : clock, synchronous active-high reset
//   ex_aluop, ex_alusel          : op within class / op class
//   ex_reg0, ex_reg1             : operands A / B
//   ex_waddr, ex_we              : destination register and write enable
//   stall_mem                    : downstream freeze from ctrl
//   ex_wdata_o, ex_waddr_o, ex_we_o : write-back bundle to ex_mem
//   stall_req                    : asks ctrl to freeze pc/if_id/id_ex
// Single-cycle ops are purely combinational; MUL/DIVU/REMU use ex_muldiv_seq.
module ex
    import ex_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MD_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ex_aluop,
    input  logic [2:0]        ex_alusel,
    input  logic [DATA_W-1:0] ex_reg0,
    input  logic [DATA_W-1:0] ex_reg1,
    input  logic [3:0]        ex_waddr,
    input  logic              ex_we,
    input  logic              stall_mem,
    output logic [DATA_W-1:0] ex_wdata_o,
    output logic [3:0]        ex_waddr_o,
    output logic              ex_we_o,
    output logic              stall_req
);

    localparam int SH_W = $clog2(DATA_W);

    logic              w_md_start;
    logic              w_md_busy;
    logic              w_md_done;
    logic [DATA_W-1:0] w_md_result;
    logic [DATA_W-1:0] w_alu;
    logic              w_we;
    logic              w_stall;
    logic [SH_W-1:0]   w_sh;

    assign w_sh = ex_reg1[SH_W-1:0];

    ex_muldiv_seq #(
        .DATA_W   (DATA_W),
        .MD_STEPS (MD_STEPS)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_hold   (stall_mem),
        .i_op     (ex_aluop),
        .i_a      (ex_reg0),
        .i_b      (ex_reg1),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // ALU result mux and write-enable qualification per op class.
    always_comb begin
        w_alu      = '0;
        w_we       = ex_we;
        w_md_start = 1'b0;
        case (ex_alusel)
            ALUSEL_NOP: begin
                w_we = WRITE_DISABLE;
            end
            ALUSEL_LOGIC: begin
                case (ex_aluop)
                    ALUOP_AND: w_alu = ex_reg0 & ex_reg1;
                    ALUOP_OR:  w_alu = ex_reg0 | ex_reg1;
                    ALUOP_XOR: w_alu = ex_reg0 ^ ex_reg1;
                    ALUOP_NOT: w_alu = ~ex_reg0;
                    default:   w_alu = '0;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (ex_aluop)
                    ALUOP_SLL: w_alu = ex_reg0 << w_sh;
                    ALUOP_SRL: w_alu = ex_reg0 >> w_sh;
                    ALUOP_SRA: w_alu = $unsigned($signed(ex_reg0) >>> w_sh);
                    default:   w_alu = '0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (ex_aluop)
                    ALUOP_ADD:  w_alu = ex_reg0 + ex_reg1;
                    ALUOP_SUB:  w_alu = ex_reg0 - ex_reg1;
                    ALUOP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(ex_reg0) < $signed(ex_reg1))};
                    ALUOP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (ex_reg0 < ex_reg1)};
                    ALUOP_NEQ:  w_alu = {{(DATA_W-1){1'b0}}, (ex_reg0 != ex_reg1)};
                    default:    w_alu = '0;
                endcase
            end
            ALUSEL_MOVE: begin
                if (ex_aluop == ALUOP_MOV) begin
                    w_alu = ex_reg0;
                end else begin
                    w_alu = '0;
                end
            end
            ALUSEL_MULDIV: begin
                // Unimplemented op codes in this class never start the unit.
                w_md_start = is_md_op(ex_aluop);
                if (w_md_start && w_md_done) begin
                    w_alu = w_md_result;
                    w_we  = ex_we;
                end else if (w_md_start) begin
                    w_alu = '0;
                    w_we  = WRITE_DISABLE;
                end else begin
                    w_alu = '0;
                    w_we  = ex_we;
                end
            end
            default: begin
                w_alu = '0;
            end
        endcase
    end

    // Stall while the unit is accepting an operation (IDLE) or iterating (BUSY);
    // DONE releases the pipeline so the next instruction arrives on the same edge.
    assign w_stall = w_md_busy | (w_md_start & ~w_md_done);

    // Reset forces the whole write-back bundle and the stall request low at once.
    always_comb begin
        if (rst == RST_ENABLE) begin
            ex_wdata_o = '0;
            ex_waddr_o = 4'd0;
            ex_we_o    = WRITE_DISABLE;
            stall_req  = STALL_NO;
        end else begin
            ex_wdata_o = w_alu;
            ex_waddr_o = ex_waddr;
            ex_we_o    = w_we;
            stall_req  = w_stall;
        end
    end

endmodule

// File: tb/tb_ex.sv
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [15:0] ex_reg0;
    logic [15:0] ex_reg1;
    logic [3:0]  ex_waddr;
    logic        ex_we;
    logic        stall_mem;
    logic [15:0] ex_wdata_o;
    logic [3:0]  ex_waddr_o;
    logic        ex_we_o;
    logic        stall_req;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  sel;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [0:14];

    ex dut (
        .clk        (clk),
        .rst        (rst),
        .ex_aluop   (ex_aluop),
        .ex_alusel  (ex_alusel),
        .ex_reg0    (ex_reg0),
        .ex_reg1    (ex_reg1),
        .ex_waddr   (ex_waddr),
        .ex_we      (ex_we),
        .stall_mem  (stall_mem),
        .ex_wdata_o (ex_wdata_o),
        .ex_waddr_o (ex_waddr_o),
        .ex_we_o    (ex_we_o),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] wa, input logic we);
        ex_alusel = sel; ex_aluop = op; ex_reg0 = a; ex_reg1 = b; ex_waddr = wa; ex_we = we;
        #1;
    endtask

    // Counts cycles with stall_req high, bounded; leaves time inside the first free cycle.
    task automatic wait_md(output int n);
        n = 0;
        while (stall_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; stall_mem = 1'b0;
        drive(ALUSEL_ARITH, ALUOP_ADD, 16'd3, 16'd2, 4'd4, 1'b1);
        checks++; if (ex_wdata_o !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h want 0000", ex_wdata_o); end
        checks++; if (ex_waddr_o !== 4'h0) begin errors++; $display("FAIL reset_waddr got %h want 0", ex_waddr_o); end
        checks++; if (ex_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ex_we_o); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
        tick(); tick();
        rst = 1'b0;
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
    endtask

    task automatic test_add;
        drive(ALUSEL_ARITH, ALUOP_ADD, 16'd3, 16'd2, 4'd4, 1'b1);
        checks++; if (ex_wdata_o !== 16'd5) begin errors++; $display("FAIL add_wdata got %h want 0005", ex_wdata_o); end
        checks++; if (ex_waddr_o !== 4'd4) begin errors++; $display("FAIL add_waddr got %h want 4", ex_waddr_o); end
        checks++; if (ex_we_o !== 1'b1) begin errors++; $display("FAIL add_we got %b want 1", ex_we_o); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL add_stall got %b want 0", stall_req); end
        tick();
    endtask

    task automatic test_alu_vectors;
        vecs[0]  = '{ALUSEL_ARITH, ALUOP_SUB,  16'h0000, 16'h0001, 16'hFFFF};
        vecs[1]  = '{ALUSEL_ARITH, ALUOP_SLT,  16'h8000, 16'h0001, 16'h0001};
        vecs[2]  = '{ALUSEL_ARITH, ALUOP_SLTU, 16'h8000, 16'h0001, 16'h0000};
        vecs[3]  = '{ALUSEL_ARITH, ALUOP_NEQ,  16'h0005, 16'h0005, 16'h0000};
        vecs[4]  = '{ALUSEL_ARITH, ALUOP_NEQ,  16'h0005, 16'h0006, 16'h0001};
        vecs[5]  = '{ALUSEL_LOGIC, ALUOP_AND,  16'hF0F0, 16'h3C3C, 16'h3030};
        vecs[6]  = '{ALUSEL_LOGIC, ALUOP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0};
        vecs[7]  = '{ALUSEL_LOGIC, ALUOP_XOR,  16'hAAAA, 16'hFFFF, 16'h5555};
        vecs[8]  = '{ALUSEL_LOGIC, ALUOP_NOT,  16'h00FF, 16'h1234, 16'hFF00};
        vecs[9]  = '{ALUSEL_SHIFT, ALUOP_SLL,  16'h0001, 16'h001F, 16'h8000};
        vecs[10] = '{ALUSEL_SHIFT, ALUOP_SRL,  16'h8000, 16'h0004, 16'h0800};
        vecs[11] = '{ALUSEL_SHIFT, ALUOP_SRA,  16'h8000, 16'h0004, 16'hF800};
        vecs[12] = '{ALUSEL_MOVE,  ALUOP_MOV,  16'h1234, 16'h5678, 16'h1234};
        vecs[13] = '{ALUSEL_LOGIC, 3'd5,       16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[14] = '{ALUSEL_ARITH, ALUOP_SLT,  16'h0001, 16'h8000, 16'h0000};
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 4'd7, 1'b1);
            checks++;
            if (ex_wdata_o !== vecs[i].exp || stall_req !== 1'b0)
                begin errors++; $display("FAIL alu_vec%0d got %h stall %b want %h stall 0", i, ex_wdata_o, stall_req, vecs[i].exp); end
            tick();
        end
        drive(ALUSEL_NOP, 3'd0, 16'h1234, 16'h1111, 4'd3, 1'b1);
        checks++; if (ex_wdata_o !== 16'h0000 || ex_we_o !== 1'b0)
            begin errors++; $display("FAIL nop got %h we %b want 0000 we 0", ex_wdata_o, ex_we_o); end
        tick();
    endtask

    task automatic test_mul_held;
        int n;
        drive(ALUSEL_MULDIV, ALUOP_MUL, 16'h0123, 16'h0010, 4'd5, 1'b1);
        checks++; if (stall_req !== 1'b1 || ex_we_o !== 1'b0)
            begin errors++; $display("FAIL mul_start got stall %b we %b want stall 1 we 0", stall_req, ex_we_o); end
        n = 0;
        while (stall_req === 1'b1 && n < 40) begin
            n++;
            // Operand changes mid-operation must not affect the result.
            if (n == 4) begin ex_reg0 = 16'hFFFF; ex_reg1 = 16'hFFFF; end
            tick();
        end
        checks++; if (n != 17) begin errors++; $display("FAIL mul_stall_cycles got %0d want 17", n); end
        checks++; if (ex_wdata_o !== 16'h1230) begin errors++; $display("FAIL mul_wdata got %h want 1230", ex_wdata_o); end
        checks++; if (ex_we_o !== 1'b1 || ex_waddr_o !== 4'd5)
            begin errors++; $display("FAIL mul_we_waddr got we %b waddr %h want 1 5", ex_we_o, ex_waddr_o); end
        stall_mem = 1'b1;
        tick(); tick();
        checks++; if (ex_wdata_o !== 16'h1230 || ex_we_o !== 1'b1 || stall_req !== 1'b0)
            begin errors++; $display("FAIL mul_hold got %h we %b stall %b want 1230 1 0", ex_wdata_o, ex_we_o, stall_req); end
        stall_mem = 1'b0;
        tick();
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        drive(ALUSEL_MULDIV, ALUOP_DIVU, 16'd100, 16'd7, 4'd2, 1'b1);
        wait_md(n);
        checks++; if (n != 17) begin errors++; $display("FAIL divu_stall_cycles got %0d want 17", n); end
        checks++; if (ex_wdata_o !== 16'd14 || ex_we_o !== 1'b1)
            begin errors++; $display("FAIL divu_wdata got %h we %b want 000e 1", ex_wdata_o, ex_we_o); end
        tick();
        drive(ALUSEL_MULDIV, ALUOP_REMU, 16'd100, 16'd7, 4'd3, 1'b1);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL remu_restart got stall %b want 1", stall_req); end
        wait_md(n);
        checks++; if (n != 17) begin errors++; $display("FAIL remu_stall_cycles got %0d want 17", n); end
        checks++; if (ex_wdata_o !== 16'd2 || ex_we_o !== 1'b1)
            begin errors++; $display("FAIL remu_wdata got %h we %b want 0002 1", ex_wdata_o, ex_we_o); end
        tick();
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
    endtask

    task automatic test_div_zero;
        int n;
        drive(ALUSEL_MULDIV, ALUOP_DIVU, 16'h1234, 16'h0000, 4'd6, 1'b1);
        wait_md(n);
        checks++; if (n != 1) begin errors++; $display("FAIL divz_stall_cycles got %0d want 1", n); end
        checks++; if (ex_wdata_o !== 16'hFFFF) begin errors++; $display("FAIL divz_wdata got %h want ffff", ex_wdata_o); end
        tick();
        drive(ALUSEL_MULDIV, ALUOP_REMU, 16'h1234, 16'h0000, 4'd6, 1'b1);
        wait_md(n);
        checks++; if (n != 1) begin errors++; $display("FAIL remz_stall_cycles got %0d want 1", n); end
        checks++; if (ex_wdata_o !== 16'h1234) begin errors++; $display("FAIL remz_wdata got %h want 1234", ex_wdata_o); end
        tick();
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        drive(ALUSEL_MULDIV, ALUOP_MUL, 16'd7, 16'd9, 4'd1, 1'b1);
        // Start edge enters BUSY with cnt=0; eight more edges reach cnt=8.
        for (int i = 0; i < 9; i++) tick();
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL mid_busy got stall %b want 1", stall_req); end
        rst = 1'b1;
        #1;
        checks++; if (ex_wdata_o !== 16'h0000 || ex_we_o !== 1'b0 || stall_req !== 1'b0)
            begin errors++; $display("FAIL mid_rst_out got %h we %b stall %b want 0000 0 0", ex_wdata_o, ex_we_o, stall_req); end
        tick();
        rst = 1'b0;
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mid_idle got stall %b want 0", stall_req); end
        tick();
        drive(ALUSEL_MULDIV, ALUOP_MUL, 16'd3, 16'd5, 4'd1, 1'b1);
        wait_md(n);
        checks++; if (n != 17) begin errors++; $display("FAIL mul35_stall_cycles got %0d want 17", n); end
        checks++; if (ex_wdata_o !== 16'd15 || ex_we_o !== 1'b1)
            begin errors++; $display("FAIL mul35_wdata got %h we %b want 000f 1", ex_wdata_o, ex_we_o); end
        tick();
        drive(ALUSEL_NOP, 3'd0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b1; stall_mem = 1'b0;
        ex_alusel = 3'd0; ex_aluop = 3'd0; ex_reg0 = 16'd0; ex_reg1 = 16'd0; ex_waddr = 4'd0; ex_we = 1'b0;
        tick();
        test_reset();
        test_add();
        test_alu_vectors();
        test_mul_held();
        test_back_to_back();
        test_div_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
